yari_sram_target: RTL and testbench

Responder end of the YARI CPU memory port (`mem_*`). It accepts single read and write requests from the core, drives a 32-bit asynchronous SRAM on the flash/SRAM/Ethernet bus, and returns tagged read data on `mem_readdata`/`mem_readdataid`. It sits between `yari` and the external SRAM pins. It takes the place of the bus_ctrl/sram_ctrl path for systems where the core is the only memory master.

---
 rtl/yari_sram_target_pkg.sv | 18 +
 rtl/yari_sram_target.sv | 159 +++++++++++++++
 tb/tb_yari_sram_target.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/yari_sram_target_pkg.sv
// Shared constants for the YARI SRAM responder: FSM encoding, tag width and burst length.
package yari_sram_target_pkg;

   localparam int MEM_ID_W = 2;
   localparam logic [MEM_ID_W-1:0] MEM_ID_NONE = 2'd0;
   localparam int BURST_LEN = 4;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_READ   = 3'd1;
   localparam logic [2:0] ST_WSETUP = 3'd2;
   localparam logic [2:0] ST_WPULSE = 3'd3;
   localparam logic [2:0] ST_WHOLD  = 3'd4;

   function automatic logic [3:0] be_n_from_mask(input logic [3:0] mask);
      return ~mask;
   endfunction

endpackage

// File: rtl/yari_sram_target.sv
// YARI memory-port responder driving a 32-bit asynchronous SRAM.
// Optional 4-word wrapping read bursts when YARI_SRAM_READ_BURST_EN is defined.
module yari_sram_target
   import yari_sram_target_pkg::*;
#(
   parameter int ADDR_W   = 18,
   parameter int RD_WAIT  = 1,
   parameter int WR_PULSE = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   output logic                mem_waitrequest,
   input  logic [MEM_ID_W-1:0] mem_id,
   input  logic [29:0]         mem_address,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [31:0]         mem_writedata,
   input  logic [3:0]          mem_writedatamask,
   output logic [31:0]         mem_readdata,
   output logic [MEM_ID_W-1:0] mem_readdataid,
   output logic [ADDR_W-1:0]   sram_a,
   inout  wire  [31:0]         sram_d,
   output logic                sram_cs_n,
   output logic                sram_oe_n,
   output logic                sram_we_n,
   output logic [3:0]          sram_be_n
);

   localparam int CNT_MAX = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] RD_FIRST_LOAD = CNT_W'(RD_WAIT);
   localparam logic [CNT_W-1:0] RD_NEXT_LOAD  = CNT_W'(RD_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD       = CNT_W'(WR_PULSE - 1);

   logic [2:0]          state_r;
   logic [CNT_W-1:0]    wait_cnt_r;
   logic [MEM_ID_W-1:0] id_r;
   logic [31:0]         wdata_r;
   logic                drive_r;
   logic                accept_s;
   logic                last_word_s;
   logic                unused_addr_s;

   assign accept_s      = (mem_read | mem_write) & ~mem_waitrequest;
   assign sram_d        = drive_r ? wdata_r : 32'hzzzz_zzzz;
   assign unused_addr_s = ^mem_address[29:ADDR_W];

`ifdef YARI_SRAM_READ_BURST_EN
   logic [1:0] beat_cnt_r;
   assign last_word_s = (beat_cnt_r == 2'(BURST_LEN - 1));
`else
   assign last_word_s = 1'b1;
`endif

   // Access sequencer: owns every registered output, the wait counter and bus ownership.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r         <= ST_IDLE;
         wait_cnt_r      <= CNT_ZERO;
         id_r            <= MEM_ID_NONE;
         wdata_r         <= 32'h0000_0000;
         drive_r         <= 1'b0;
         mem_waitrequest <= 1'b1;
         mem_readdata    <= 32'h0000_0000;
         mem_readdataid  <= MEM_ID_NONE;
         sram_a          <= {ADDR_W{1'b0}};
         sram_cs_n       <= 1'b1;
         sram_oe_n       <= 1'b1;
         sram_we_n       <= 1'b1;
         sram_be_n       <= 4'hF;
`ifdef YARI_SRAM_READ_BURST_EN
         beat_cnt_r      <= 2'd0;
`endif
      end else begin
         mem_readdataid <= MEM_ID_NONE;
         case (state_r)
            ST_IDLE: begin
               mem_waitrequest <= 1'b0;
               if (accept_s) begin
                  mem_waitrequest <= 1'b1;
                  id_r            <= mem_id;
                  sram_a          <= mem_address[ADDR_W-1:0];
                  sram_cs_n       <= 1'b0;
                  // A simultaneous read is dropped; the write wins.
                  if (mem_write) begin
                     state_r   <= ST_WSETUP;
                     wdata_r   <= mem_writedata;
                     drive_r   <= 1'b1;
                     sram_be_n <= be_n_from_mask(mem_writedatamask);
                  end else begin
                     state_r    <= ST_READ;
                     sram_be_n  <= 4'h0;
                     wait_cnt_r <= RD_FIRST_LOAD;
`ifdef YARI_SRAM_READ_BURST_EN
                     beat_cnt_r <= 2'd0;
`endif
                  end
               end
            end
            ST_READ: begin
               sram_oe_n <= 1'b0;
               if (wait_cnt_r == CNT_ZERO) begin
                  mem_readdata   <= sram_d;
                  mem_readdataid <= id_r;
                  if (last_word_s) begin
                     state_r         <= ST_IDLE;
                     mem_waitrequest <= 1'b0;
                     sram_cs_n       <= 1'b1;
                     sram_oe_n       <= 1'b1;
                     sram_be_n       <= 4'hF;
                  end
`ifdef YARI_SRAM_READ_BURST_EN
                  else begin
                     // Wrap within the aligned 4-word block, critical word first.
                     beat_cnt_r  <= beat_cnt_r + 2'd1;
                     sram_a[1:0] <= sram_a[1:0] + 2'd1;
                     wait_cnt_r  <= RD_NEXT_LOAD;
                  end
`endif
               end else begin
                  wait_cnt_r <= wait_cnt_r - CNT_ONE;
               end
            end
            ST_WSETUP: begin
               state_r    <= ST_WPULSE;
               sram_we_n  <= 1'b0;
               wait_cnt_r <= WR_LOAD;
            end
            ST_WPULSE: begin
               if (wait_cnt_r == CNT_ZERO) begin
                  state_r   <= ST_WHOLD;
                  sram_we_n <= 1'b1;
               end else begin
                  wait_cnt_r <= wait_cnt_r - CNT_ONE;
               end
            end
            ST_WHOLD: begin
               state_r         <= ST_IDLE;
               mem_waitrequest <= 1'b0;
               drive_r         <= 1'b0;
               sram_cs_n       <= 1'b1;
               sram_be_n       <= 4'hF;
            end
            default: begin
               state_r         <= ST_IDLE;
               mem_waitrequest <= 1'b1;
               drive_r         <= 1'b0;
               sram_cs_n       <= 1'b1;
               sram_oe_n       <= 1'b1;
               sram_we_n       <= 1'b1;
               sram_be_n       <= 4'hF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_yari_sram_target.sv
// Directed bench for yari_sram_target with a behavioural async SRAM and a bus keeper.
module tb_yari_sram_target;

`ifdef YARI_SRAM_READ_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif
   localparam logic [31:0] KEEP = 32'hC3C3_C3C3;
   localparam int SPACE   = BURST ? 6 : 3;
   localparam int B2B_WR  = BURST ? 3 : 5;
   localparam int B2B_IDS = BURST ? 8 : 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mem_waitrequest;
   logic [1:0]  mem_id;
   logic [29:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_writedatamask;
   logic [31:0] mem_readdata;
   logic [1:0]  mem_readdataid;
   logic [17:0] sram_a;
   wire  [31:0] sram_d;
   logic        sram_cs_n;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic [3:0]  sram_be_n;

   logic [31:0] mem [0:1023];
   int checks = 0;
   int failures = 0;

   yari_sram_target #(.ADDR_W(18), .RD_WAIT(1), .WR_PULSE(1)) dut (
      .clk(clk), .reset_n(reset_n), .mem_waitrequest(mem_waitrequest),
      .mem_id(mem_id), .mem_address(mem_address), .mem_read(mem_read),
      .mem_write(mem_write), .mem_writedata(mem_writedata),
      .mem_writedatamask(mem_writedatamask), .mem_readdata(mem_readdata),
      .mem_readdataid(mem_readdataid), .sram_a(sram_a), .sram_d(sram_d),
      .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_be_n(sram_be_n)
   );

   always #20 clk = ~clk;

   // Keeper pattern whenever the chip is deselected; SRAM drives on an output-enabled read.
   assign sram_d = sram_cs_n ? KEEP :
                   ((!sram_oe_n && sram_we_n) ? mem[sram_a[9:0]] : 32'hzzzz_zzzz);

   always @(posedge clk) begin
      if (!sram_cs_n && !sram_we_n) begin
         for (int b = 0; b < 4; b++) begin
            if (!sram_be_n[b]) mem[sram_a[9:0]][8*b +: 8] <= sram_d[8*b +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (mem_waitrequest && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (mem_waitrequest) chk({tag, "_timeout"}, 32'(mem_waitrequest), 32'd0);
   endtask

   task automatic do_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                           output int busy, output int we_low, output logic [3:0] be_seen);
      wait_ready("wr_ready");
      mem_write = 1'b1; mem_address = a; mem_writedata = d; mem_writedatamask = m; mem_id = 2'd1;
      @(posedge clk);
      @(negedge clk);
      mem_write = 1'b0;
      busy = 0; we_low = 0; be_seen = 4'h5;
      for (int i = 0; i < 20; i++) begin
         if (!mem_waitrequest) break;
         busy++;
         if (!sram_we_n) we_low++;
         if (!sram_cs_n) be_seen = sram_be_n;
         @(negedge clk);
      end
   endtask

   task automatic do_read(input logic [29:0] a, input logic [1:0] id, output logic [31:0] d,
                          output logic [1:0] rid, output int lat, output logic wr);
      wait_ready("rd_ready");
      mem_read = 1'b1; mem_address = a; mem_id = id;
      @(posedge clk);
      @(negedge clk);
      mem_read = 1'b0;
      lat = 0;
      while (mem_readdataid == 2'd0 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      d = mem_readdata; rid = mem_readdataid; wr = mem_waitrequest;
   endtask

   initial begin
      int busy, wel, lat, wr_low, ids, last, bad_space, seen, n, first, lastk, wr_early;
      logic [3:0] be;
      logic [31:0] d;
      logic [1:0] rid;
      logic wr, wr_last;
      logic [31:0] got [4];

      for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0000;
      mem_id = 2'd0; mem_address = 30'd0; mem_read = 1'b0; mem_write = 1'b0;
      mem_writedata = 32'd0; mem_writedatamask = 4'h0;

      repeat (2) @(negedge clk);
      chk("rst_wait", 32'(mem_waitrequest), 32'd1);
      chk("rst_rdid", 32'(mem_readdataid), 32'd0);
      chk("rst_rdata", mem_readdata, 32'd0);
      chk("rst_strobes", 32'({sram_cs_n, sram_oe_n, sram_we_n, sram_be_n}), 32'h7F);
      chk("rst_addr", 32'(sram_a), 32'd0);
      chk("rst_bus", sram_d, KEEP);
      reset_n = 1'b1;
      #1 chk("rel_wait_high", 32'(mem_waitrequest), 32'd1);
      @(negedge clk);
      chk("rel_wait_fall", 32'(mem_waitrequest), 32'd0);

      do_write(30'h100, 32'hDEAD_BEEF, 4'hF, busy, wel, be);
      chk("wr_busy", 32'(busy), 32'd3);
      chk("wr_we_pulse", 32'(wel), 32'd1);
      chk("wr_be", 32'(be), 32'h0);
      do_read(30'h100, 2'd2, d, rid, lat, wr);
      chk("rd_id", 32'(rid), 32'd2);
      chk("rd_data", d, 32'hDEAD_BEEF);
      chk("rd_lat", 32'(lat), 32'd2);
      chk("rd_wait_at_data", 32'(wr), 32'(BURST));
`ifndef YARI_SRAM_READ_BURST_EN
      @(negedge clk);
      chk("rd_single_word", 32'(mem_readdataid), 32'd0);
`endif

      do_write(30'h100, 32'h0000_00AA, 4'b0001, busy, wel, be);
      chk("mwr_be", 32'(be), 32'hE);
      chk("mwr_busy", 32'(busy), 32'd3);
      do_read(30'h100, 2'd1, d, rid, lat, wr);
      chk("mrd_data", d, 32'hDEAD_BEAA);
      chk("mrd_id", 32'(rid), 32'd1);
      do_read(30'h2000_0100, 2'd3, d, rid, lat, wr);
      chk("upper_addr_ignored", d, 32'hDEAD_BEAA);

      do_write(30'h100, 32'hFFFF_FFFF, 4'h0, busy, wel, be);
      chk("zmask_be", 32'(be), 32'hF);
      chk("zmask_busy", 32'(busy), 32'd3);
      do_read(30'h100, 2'd1, d, rid, lat, wr);
      chk("zmask_data", d, 32'hDEAD_BEAA);

      // Reads held continuously: accepts land every SPACE edges.
      wait_ready("b2b_ready");
      mem_read = 1'b1; mem_address = 30'h100; mem_id = 2'd3;
      wr_low = 0; ids = 0; last = -1; bad_space = 0;
      for (int k = 0; k < 13; k++) begin
         if (!mem_waitrequest) begin
            if (last >= 0 && (k - last) != SPACE) bad_space++;
            last = k;
            wr_low++;
         end
         if (mem_readdataid == 2'd3) ids++;
         if (k < 12) @(negedge clk);
      end
      mem_read = 1'b0;
      chk("b2b_wait_low", 32'(wr_low), 32'(B2B_WR));
      chk("b2b_returns", 32'(ids), 32'(B2B_IDS));
      chk("b2b_spacing", 32'(bad_space), 32'd0);

      wait_ready("rw_ready");
      mem_read = 1'b1; mem_write = 1'b1; mem_address = 30'h101;
      mem_writedata = 32'h1234_5678; mem_writedatamask = 4'hF; mem_id = 2'd2;
      @(posedge clk);
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      busy = 0; seen = 0;
      for (int k = 0; k < 8; k++) begin
         if (mem_waitrequest) busy++;
         if (mem_readdataid != 2'd0) seen++;
         @(negedge clk);
      end
      chk("rw_busy", 32'(busy), 32'd3);
      chk("rw_no_id", 32'(seen), 32'd0);
      do_read(30'h101, 2'd1, d, rid, lat, wr);
      chk("rw_write_done", d, 32'h1234_5678);

      wait_ready("rstw_ready");
      mem_write = 1'b1; mem_address = 30'h102; mem_writedata = 32'hDEAD_BEEF;
      mem_writedatamask = 4'hF; mem_id = 2'd1;
      @(posedge clk);
      @(negedge clk);
      mem_write = 1'b0;
      @(negedge clk);
      chk("rstw_in_pulse", 32'(sram_we_n), 32'd0);
      reset_n = 1'b0;
      #1;
      chk("rstw_strobes", 32'({sram_cs_n, sram_oe_n, sram_we_n, sram_be_n}), 32'h7F);
      chk("rstw_bus", sram_d, KEEP);
      chk("rstw_wait", 32'(mem_waitrequest), 32'd1);
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (mem_readdataid != 2'd0) seen++;
      end
      reset_n = 1'b1;
      #1 chk("rstw_rel_wait", 32'(mem_waitrequest), 32'd1);
      @(negedge clk);
      if (mem_readdataid != 2'd0) seen++;
      chk("rstw_rel_fall", 32'(mem_waitrequest), 32'd0);
      chk("rstw_no_id", 32'(seen), 32'd0);
      do_read(30'h100, 2'd2, d, rid, lat, wr);
      chk("rstw_after_data", d, 32'hDEAD_BEAA);
      chk("rstw_after_lat", 32'(lat), 32'd2);

`ifdef YARI_SRAM_READ_BURST_EN
      for (int i = 0; i < 4; i++) begin
         do_write(30'h100 + 30'(i), 32'(i), 4'hF, busy, wel, be);
      end
      wait_ready("burst_ready");
      mem_read = 1'b1; mem_address = 30'h102; mem_id = 2'd2;
      @(posedge clk);
      @(negedge clk);
      mem_read = 1'b0;
      n = 0; first = -1; lastk = -1; wr_early = 0; wr_last = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (mem_readdataid == 2'd2 && n < 4) begin
            if (first < 0) first = k;
            lastk = k;
            got[n] = mem_readdata;
            if (n < 3 && !mem_waitrequest) wr_early++;
            if (n == 3) wr_last = mem_waitrequest;
            n++;
         end
         @(negedge clk);
      end
      chk("burst_count", 32'(n), 32'd4);
      chk("burst_w0", got[0], 32'd2);
      chk("burst_w1", got[1], 32'd3);
      chk("burst_w2", got[2], 32'd0);
      chk("burst_w3", got[3], 32'd1);
      chk("burst_span", 32'(lastk - first), 32'd3);
      chk("burst_wait_early", 32'(wr_early), 32'd0);
      chk("burst_wait_last", 32'(wr_last), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
